instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Multi-cycle instruction fetch stage that produces the opcode and instruction fields consumed by the control unit.
- Owns the PC and runs a req/ack handshake with instruction memory.
- Holds the fetched word in an instruction register and presents its decoded fields with a valid flag.
- Computes the next PC from the Branch and zero results fed back from decode/execute.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment between sequential instructions

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  fetch address; equals PC
imem_ack  input  1  memory has imem_rdata valid this cycle
imem_rdata  input  32  instruction word
stall  input  1  downstream not ready; hold current instruction
branch  input  1  Branch control from decoder for current instruction
zero  input  1  ALU zero flag for current instruction
instr_valid  output  1  instruction fields below are valid
op  output  6  IR[31:26]
rs  output  5  IR[25:21]
rt  output  5  IR[20:16]
rd  output  5  IR[15:11]
funct  output  6  IR[5:0]
imm  output  16  IR[15:0]
pc_out  output  ADDR_W  address of instruction in IR
pc_plus4  output  ADDR_W  pc_out + PC_STEP
instr_count  output  32  number of instructions retired; wraps at 2^32

Behaviour:
Reset (rst_n low, asynchronous):
- State goes to REQ.
- PC = RESET_PC. IR = 0, so op = 0.
- imem_req = 0, instr_valid = 0, instr_count = 0.
- pc_out = RESET_PC.
- Any in-flight ack is discarded.

State machine (states REQ, WAIT, ISSUE):
- REQ, entered from reset:
  - Drive imem_req = 1 in the first cycle after rst_n deasserts.
  - imem_addr = PC.
  - If imem_ack is also 1 that cycle: capture imem_rdata into IR and go to ISSUE. Zero-wait latency is 1 cycle.
  - Otherwise go to WAIT.
- WAIT:
  - imem_req stays 1; imem_addr is held stable.
  - On imem_ack: capture IR and go to ISSUE.
  - No timeout.
- ISSUE:
  - imem_req = 0, instr_valid = 1.
  - IR, pc_out and all fields are held stable while stall = 1.
  - When stall = 0, the instruction retires:
    - instr_count increments.
    - If branch & zero: PC <= pc_plus4 + (sign_extend(imm) << 2). Arithmetic is mod 2^ADDR_W; wrap is allowed.
    - Else: PC <= pc_plus4.
    - Next state is REQ, with instr_valid = 0 in that cycle.
- branch and zero are sampled only in the ISSUE & !stall cycle; they are ignored in all other cycles.
- imem_ack is ignored while imem_req = 0.
- Throughput: at least 2 cycles per instruction (REQ + ISSUE).
- pc_plus4 is combinational from pc_out.
- instr_count wraps from 32'hFFFF_FFFF to 0.
- Stall during REQ/WAIT has no effect; stall only matters in ISSUE.

Test Plan:
- Reset with RESET_PC = 0 -> imem_req = 0, instr_valid = 0, op = 0, instr_count = 0. First cycle after release: imem_req = 1, imem_addr = 0.
- Zero-wait memory returning 0x8C220004 then 0x00430820 -> issues at PC 0 then PC 4.
  - First instruction: op = 6'b100011, rs = 1, rt = 2, imm = 4.
  - Second instruction: op = 0, funct = 6'h20.
  - instr_count = 2; each instruction takes 2 cycles.
- Ack delayed 3 cycles -> imem_req high and imem_addr constant for all 4 cycles. Fields are valid the cycle after ack.
- Hold stall = 1 for 5 ISSUE cycles -> all fields, pc_out and instr_valid stable, and no new request.
  - After stall drops: instr_count += 1 and the next imem_addr = pc + 4.
- beq at PC 0x40 with imm = 16'hFFFC, branch = 1, zero = 1 -> next imem_addr = 0x44 - 16 = 0x34.
  - Same instruction with zero = 0 -> next imem_addr = 0x44.
- Assert rst_n low in the middle of WAIT, then pulse imem_ack while in reset -> outputs return to reset values. The first request after release is at RESET_PC and the stale ack is not captured.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Multi-cycle instruction fetch stage. Owns the PC and runs a req/ack
//   handshake with instruction memory. It latches the returned word into an
//   instruction register and presents the decoded fields with a valid flag.
//   On retire it computes the next PC from the branch/zero feedback.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   imem_req      fetch request (high in REQ/WAIT)
//   imem_addr     fetch address (= PC)
//   imem_ack      imem_rdata valid this cycle (ignored while imem_req = 0)
//   imem_rdata    instruction word
//   stall         hold the current instruction while in ISSUE
//   branch, zero  branch decision inputs, sampled only on retire
//   instr_valid   decoded fields valid
//   op/rs/rt/rd/funct/imm  IR fields
//   pc_out        address of the instruction in IR
//   pc_plus4      pc_out + PC_STEP
//   instr_count   retired instruction count (wraps)
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch,
  input  logic              zero,
  output logic              instr_valid,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [5:0]        funct,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [31:0]       instr_count
);

  typedef enum logic [1:0] {REQ, WAIT, ISSUE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q;
  logic [31:0]       count_q;
  logic              ir_load;
  logic              retire;
  logic [ADDR_W-1:0] br_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= REQ;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ir_load = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      REQ: begin
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          retire  = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  // REQ is the reset state, so gating with rst_n keeps imem_req low while
  // reset is held and raises it in the first cycle after release.
  assign imem_req    = rst_n && (state_q != ISSUE);
  assign instr_valid = (state_q == ISSUE);

  // PC only advances on retire, so during ISSUE it still addresses the
  // instruction held in IR.
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign pc_plus4  = pc_q + ADDR_W'(PC_STEP);

  // Word offset: sign-extended immediate shifted left by two.
  assign br_off = {{(ADDR_W-18){ir_q[15]}}, ir_q[15:0], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      count_q <= '0;
    end else begin
      if (ir_load) ir_q <= imem_rdata;
      if (retire) begin
        count_q <= count_q + 32'd1;
        if (branch && zero) pc_q <= pc_plus4 + br_off;
        else                pc_q <= pc_plus4;
      end
    end
  end

  assign op          = ir_q[31:26];
  assign rs          = ir_q[25:21];
  assign rt          = ir_q[20:16];
  assign rd          = ir_q[15:11];
  assign funct       = ir_q[5:0];
  assign imm         = ir_q[15:0];
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: table of fetch vectors applied in a loop,
// scoreboard queue of expected decodes, and hand-written reset sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch;
  logic        zero;
  logic        instr_valid;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] pc_out, pc_plus4, instr_count;

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch(branch), .zero(zero),
    .instr_valid(instr_valid),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          lat;      // cycles in WAIT before ack
    int          stl;      // extra ISSUE cycles held by stall
    logic        br;
    logic        z;
    logic [5:0]  e_op;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic [5:0]  e_funct;
    logic [15:0] e_imm;
    logic [31:0] e_next;   // next fetch address after retire
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;
  } exp_t;

  vec_t        vecs[9];
  exp_t        sb[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input exp_t e);
    chk({tag, "_op"},    {26'd0, op},    {26'd0, e.op});
    chk({tag, "_rs"},    {27'd0, rs},    {27'd0, e.rs});
    chk({tag, "_rt"},    {27'd0, rt},    {27'd0, e.rt});
    chk({tag, "_rd"},    {27'd0, rd},    {27'd0, e.rd});
    chk({tag, "_funct"}, {26'd0, funct}, {26'd0, e.funct});
    chk({tag, "_imm"},   {16'd0, imm},   {16'd0, e.imm});
    chk({tag, "_pc"},    pc_out,         e.pc);
    chk({tag, "_pc4"},   pc_plus4,       e.pc + 32'd4);
  endtask

  // Entered at a negedge where a request is expected; returns at the negedge
  // after retire.
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    chk($sformatf("v%0d_req", idx), {31'd0, imem_req}, 32'd1);
    chk($sformatf("v%0d_addr", idx), imem_addr, exp_pc);
    for (int c = 0; c < v.lat; c++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("v%0d_wait_req", idx), {31'd0, imem_req}, 32'd1);
      chk($sformatf("v%0d_wait_addr", idx), imem_addr, exp_pc);
      chk($sformatf("v%0d_wait_valid", idx), {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = v.word;
    e.pc = exp_pc; e.op = v.e_op; e.rs = v.e_rs; e.rt = v.e_rt;
    e.rd = v.e_rd; e.funct = v.e_funct; e.imm = v.e_imm;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk($sformatf("v%0d_valid", idx), {31'd0, instr_valid}, 32'd1);
    chk($sformatf("v%0d_issue_req", idx), {31'd0, imem_req}, 32'd0);
    if (instr_valid && sb.size() > 0) e = sb.pop_front();
    chk_fields($sformatf("v%0d", idx), e);
    if (v.stl > 0) begin
      stall = 1'b1;
      for (int s = 0; s < v.stl; s++) begin
        // A stray ack while no request is outstanding must be ignored.
        imem_ack   = (s == 1);
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        imem_ack = 1'b0;
        chk($sformatf("v%0d_stall_valid", idx), {31'd0, instr_valid}, 32'd1);
        chk($sformatf("v%0d_stall_req", idx), {31'd0, imem_req}, 32'd0);
        chk($sformatf("v%0d_stall_cnt", idx), instr_count, exp_cnt);
        chk_fields($sformatf("v%0d_stall", idx), e);
      end
    end
    stall  = 1'b0;
    branch = v.br;
    zero   = v.z;
    @(posedge clk); @(negedge clk);
    branch = 1'b1;  // outside the retire cycle these must have no effect
    zero   = 1'b1;
    exp_cnt = exp_cnt + 32'd1;
    exp_pc  = v.e_next;
    chk($sformatf("v%0d_ret_valid", idx), {31'd0, instr_valid}, 32'd0);
    chk($sformatf("v%0d_ret_cnt", idx), instr_count, exp_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           word           lat stl br  z   op     rs     rt     rd      funct   imm       next
    vecs[0] = '{32'h8C22_0004, 0, 0, 0, 0, 6'h23, 5'd1, 5'd2, 5'd0,  6'h04, 16'h0004, 32'h04};
    vecs[1] = '{32'h0043_0820, 0, 0, 0, 0, 6'h00, 5'd2, 5'd3, 5'd1,  6'h20, 16'h0820, 32'h08};
    vecs[2] = '{32'h2001_0005, 3, 0, 0, 0, 6'h08, 5'd0, 5'd1, 5'd0,  6'h05, 16'h0005, 32'h0C};
    vecs[3] = '{32'h1100_0004, 1, 5, 1, 1, 6'h04, 5'd8, 5'd0, 5'd0,  6'h04, 16'h0004, 32'h20};
    vecs[4] = '{32'h1000_0007, 0, 0, 1, 1, 6'h04, 5'd0, 5'd0, 5'd0,  6'h07, 16'h0007, 32'h40};
    vecs[5] = '{32'h1000_FFFC, 2, 0, 1, 1, 6'h04, 5'd0, 5'd0, 5'd31, 6'h3C, 16'hFFFC, 32'h34};
    vecs[6] = '{32'h1000_0002, 0, 0, 1, 1, 6'h04, 5'd0, 5'd0, 5'd0,  6'h02, 16'h0002, 32'h40};
    vecs[7] = '{32'h1000_FFFC, 0, 0, 1, 0, 6'h04, 5'd0, 5'd0, 5'd31, 6'h3C, 16'hFFFC, 32'h44};
    vecs[8] = '{32'h1000_FFFC, 0, 0, 0, 1, 6'h04, 5'd0, 5'd0, 5'd31, 6'h3C, 16'hFFFC, 32'h48};

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; branch = 1'b1; zero = 1'b1;
    exp_pc = 32'h0; exp_cnt = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_op",    {26'd0, op},          32'd0);
    chk("rst_cnt",   instr_count,          32'd0);
    chk("rst_pc",    pc_out,               32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset asserted in the middle of WAIT, stale ack pulsed during reset.
    chk("mid_req", {31'd0, imem_req}, 32'd1);
    chk("mid_addr", imem_addr, 32'h48);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req",   {31'd0, imem_req},    32'd0);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_cnt",   instr_count,          32'd0);
    chk("mid_rst_pc",    pc_out,               32'd0);
    chk("mid_rst_op",    {26'd0, op},          32'd0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_valid", {31'd0, instr_valid}, 32'd0);
    chk("post_op",    {26'd0, op},          32'd0);
    chk("post_imm",   {16'd0, imm},         32'd0);
    exp_pc = 32'h0; exp_cnt = 32'h0;
    sb.delete();
    run_vec(100, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
